// File: rtl/median_window_filter_if.sv
// median_window_filter_if: sample-in / median-out handshake bundle for median_window_filter
interface median_window_filter_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, out_valid, out_ready, full;
  logic [WIDTH-1:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, full);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, full);
endinterface

// File: rtl/median_window_filter.sv
// median_window_filter: median of the last WINDOW samples via odd-even transposition sort; define MEDIAN_SIGNED_EN for signed compares
module median_window_filter #(
  parameter int WIDTH = 16,
  parameter int WINDOW = 9
) (
  input  logic clk,
  input  logic HARD_RESET,
  input  logic clr,
  median_window_filter_if.slave bus
);
  localparam int PW = $clog2(WINDOW);
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] WIN = CW'(WINDOW);
  localparam logic [PW-1:0] LAST = PW'(WINDOW - 1);
  typedef enum logic [1:0] {IDLE, SORT, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ring_q [WINDOW];
  logic [WIDTH-1:0] ring_d [WINDOW];
  logic [WIDTH-1:0] arr_q [WINDOW];
  logic [WIDTH-1:0] arr_d [WINDOW];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] fill_q, fill_d, stage_q, stage_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, full_q, full_d;
  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MEDIAN_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction
  // Stage parity picks the pair set: even stages compare (0,1),(2,3)..., odd stages (1,2),(3,4)...
  always_comb begin
    state_d = state_q;
    ring_d = ring_q;
    arr_d = arr_q;
    wptr_d = wptr_q;
    fill_d = fill_q;
    stage_d = stage_q;
    out_data_d = out_data_q;
    if (clr) begin
      state_d = IDLE;
      wptr_d = '0;
      fill_d = '0;
      stage_d = '0;
      for (int i = 0; i < WINDOW; i++) ring_d[i] = '0;
    end else if (state_q == IDLE) begin
      if (bus.in_valid) begin
        ring_d[wptr_q] = bus.in_data;
        wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
        fill_d = (fill_q == WIN) ? WIN : fill_q + CW'(1);
        if (fill_d == WIN) begin
          arr_d = ring_d;
          state_d = SORT;
          stage_d = '0;
        end
      end
    end else if (state_q == SORT) begin
      if (stage_q == WIN) begin
        state_d = HOLD;
        out_data_d = arr_q[WINDOW/2];
      end else begin
        stage_d = stage_q + CW'(1);
        for (int i = 0; i + 1 < WINDOW; i++)
          if (i[0] == stage_q[0] && gt(arr_q[i], arr_q[i+1])) begin
            arr_d[i] = arr_q[i+1];
            arr_d[i+1] = arr_q[i];
          end
      end
    end else if (bus.out_ready) begin
      state_d = IDLE;
    end
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == HOLD;
    full_d = fill_d == WIN;
  end
  always_ff @(posedge clk or posedge HARD_RESET) begin
    if (HARD_RESET) begin
      state_q <= IDLE;
      wptr_q <= '0;
      fill_q <= '0;
      stage_q <= '0;
      out_data_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      full_q <= 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
        ring_q[i] <= '0;
        arr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      stage_q <= stage_d;
      out_data_q <= out_data_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      full_q <= full_d;
      ring_q <= ring_d;
      arr_q <= arr_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.full = full_q;
endmodule

// File: tb/tb_median_window_filter.sv
// tb_median_window_filter: directed stimulus checked against a sample-history median model
module tb_median_window_filter;
  localparam int W = 9;
  localparam int WD = 16;
  logic clk, rst, clr, ordy_g, chk_on;
  int checks = 0, errors = 0;
  logic [WD-1:0] hist[$];
  int m_fill = 0, m_cnt = 0;
  logic m_busy = 0, m_valid = 0;
  logic [WD-1:0] m_med = '0;
  median_window_filter_if #(.WIDTH(WD)) bus ();
  median_window_filter #(.WIDTH(WD), .WINDOW(W)) dut (.clk(clk), .HARD_RESET(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic mgt(input logic [WD-1:0] a, input logic [WD-1:0] b);
`ifdef MEDIAN_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction
  function automatic logic [WD-1:0] median();
    logic [WD-1:0] a [W];
    logic [WD-1:0] t;
    for (int i = 0; i < W; i++) a[i] = hist[i];
    for (int i = 0; i < W; i++)
      for (int j = 0; j + 1 < W - i; j++)
        if (mgt(a[j], a[j+1])) begin
          t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
        end
    return a[W/2];
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask
  task automatic model_clear();
    hist.delete();
    m_fill = 0;
    m_busy = 0;
    m_valid = 0;
    m_cnt = 0;
  endtask
  task automatic model_edge();
    if (clr) model_clear();
    else if (!m_busy) begin
      if (bus.in_valid) begin
        hist.push_back(bus.in_data);
        if (hist.size() > W) void'(hist.pop_front());
        if (m_fill < W) m_fill++;
        if (m_fill == W) begin
          m_busy = 1;
          m_cnt = W + 1;
          m_med = median();
        end
      end
    end else if (!m_valid) begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1;
    end else if (bus.out_ready) begin
      m_valid = 0;
      m_busy = 0;
    end
  endtask
  task automatic cycle(input logic v, input logic [WD-1:0] d, input logic ordy, input logic c);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = ordy;
    clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic accept(input logic [WD-1:0] d);
    int k = 0;
    while (!bus.in_ready && k < 40) begin
      cycle(0, '0, ordy_g, 0);
      k++;
    end
    check("accept_ready", {31'b0, bus.in_ready}, 1);
    cycle(1, d, ordy_g, 0);
  endtask
  task automatic wait_med(input string name, input logic [WD-1:0] exp);
    int k = 0;
    while (!bus.out_valid && k < 30) begin
      cycle(0, '0, ordy_g, 0);
      k++;
    end
    check({name, "_valid"}, {31'b0, bus.out_valid}, 1);
    check({name, "_data"}, {16'b0, bus.out_data}, {16'b0, exp});
  endtask
  task automatic quiet(input string name, input int n);
    logic seen = 0;
    for (int i = 0; i < n; i++) begin
      cycle(0, '0, ordy_g, 0);
      seen |= bus.out_valid;
    end
    check(name, {31'b0, seen}, 0);
  endtask
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("cmp_in_ready", {31'b0, bus.in_ready}, {31'b0, !m_busy});
      check("cmp_out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
      check("cmp_full", {31'b0, bus.full}, {31'b0, m_fill == W});
      if (m_valid) check("cmp_out_data", {16'b0, bus.out_data}, {16'b0, m_med});
    end
  end
  initial begin
    int lat;
    logic [WD-1:0] held;
    logic [WD-1:0] seq [W] = '{16'd5, 16'd1, 16'd9, 16'd3, 16'd7, 16'd2, 16'd8, 16'd6, 16'd4};
    clk = 0;
    rst = 1;
    clr = 0;
    chk_on = 0;
    ordy_g = 1;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 1;
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_out_data", {16'b0, bus.out_data}, 0);
    check("rst_full", {31'b0, bus.full}, 0);
    #20;
    rst = 0;
    chk_on = 1;
    for (int i = 0; i < W; i++) begin
      cycle(1, seq[i], 1, 0);
      if (i < W - 1) check("pre9_no_valid", {31'b0, bus.out_valid}, 0);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(0, '0, 1, 0);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 10);
    check("first_median", {16'b0, bus.out_data}, 5);
    check("full_set", {31'b0, bus.full}, 1);
    accept(16'd100);
    wait_med("slide100", 16'd6);
    accept(16'd0);
    wait_med("slide0", 16'd6);
    check("full_stays", {31'b0, bus.full}, 1);
    accept(16'd1000);
    ordy_g = 0;
    wait_med("bp", 16'd6);
    held = bus.out_data;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 16'd777, 0, 0);
      check("bp_stable", {16'b0, bus.out_data}, {16'b0, held});
      check("bp_no_ready", {31'b0, bus.in_ready}, 0);
    end
    cycle(0, '0, 1, 0);
    check("bp_release_valid", {31'b0, bus.out_valid}, 0);
    check("bp_release_ready", {31'b0, bus.in_ready}, 1);
    ordy_g = 1;
    accept(16'd1);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    cycle(1, 16'd123, 1, 1);
    check("clr_full", {31'b0, bus.full}, 0);
    check("clr_valid", {31'b0, bus.out_valid}, 0);
    check("clr_ready", {31'b0, bus.in_ready}, 1);
    for (int i = 1; i <= 8; i++) accept(WD'(10 * i));
    quiet("clr_8_quiet", 15);
    accept(16'd90);
    wait_med("clr_refill", 16'd50);
    accept(16'd5);
    ordy_g = 0;
    wait_med("pre_rst", 16'd50);
    #1;
    rst = 1;
    model_clear();
    #1;
    check("arst_valid", {31'b0, bus.out_valid}, 0);
    check("arst_data", {16'b0, bus.out_data}, 0);
    check("arst_ready", {31'b0, bus.in_ready}, 1);
    check("arst_full", {31'b0, bus.full}, 0);
    #1;
    rst = 0;
    ordy_g = 1;
    for (int i = 0; i < 5; i++) accept(16'hFFFF);
    for (int i = 0; i < 3; i++) accept(16'h0001);
    quiet("rst_8_quiet", 15);
    accept(16'h0001);
    wait_med("neg_major", 16'hFFFF);
    cycle(0, '0, 1, 1);
    for (int i = 0; i < 5; i++) accept(16'h0001);
    for (int i = 0; i < 4; i++) accept(16'hFFFF);
    wait_med("pos_major", 16'h0001);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_window_filter.md
MEDIAN_WINDOW_FILTER -- requirements
Module: median_window_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the sample width in bits.
REQ-002 The block SHALL have parameter WINDOW, default 9, giving the window length: odd, legal range 3..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port HARD_RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous flush of window and control.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the incoming sample.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a median.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the median.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the median of the last WINDOW samples.
REQ-012 The block SHALL have port full, output, 1 bit: WINDOW samples have been accepted since reset or clr.

Function
REQ-013 The block SHALL keep an age-ordered ring of WINDOW samples plus a fill counter that saturates at WINDOW.
REQ-014 The block SHALL implement an FSM with exactly three states: IDLE, SORT, HOLD.
REQ-015 The block SHALL drive in_ready=1 only in IDLE; an accept is a clk edge with in_valid=1 and in_ready=1.
REQ-016 On accept, the block SHALL overwrite the oldest ring entry with in_data and advance the write pointer, wrapping from WINDOW-1 to 0.
REQ-017 On an accept with the post-accept fill count equal to WINDOW, the block SHALL copy the ring, new sample included, into a sort array and enter SORT; otherwise it SHALL stay in IDLE with no output.
REQ-018 In SORT, the block SHALL perform exactly one odd-even transposition stage per cycle over WINDOW cycles, alternating even-pair and odd-pair stages starting with even, ascending order.
REQ-019 After the last SORT stage, the block SHALL enter HOLD, assert out_valid and drive out_data = sorted[WINDOW/2].
REQ-020 The latency SHALL be: accept at edge t gives out_valid=1 after edge t+WINDOW+1.
REQ-021 In HOLD, out_data and out_valid SHALL remain stable until an edge with out_ready=1, after which the FSM SHALL return to IDLE and out_valid SHALL be 0.
REQ-022 The block SHALL NOT accept a new sample while in SORT or HOLD; in_valid SHALL be ignored there.
REQ-023 Samples with equal values SHALL NOT be swapped during sorting.
REQ-024 By default, all comparisons SHALL be unsigned.
REQ-025 On clr=1 at an edge, the block SHALL set the fill counter and write pointer to 0, zero the ring, enter IDLE and set out_valid to 0; clr SHALL override any simultaneous accept or out_ready, and a sample presented in that cycle SHALL be dropped.
REQ-026 clr asserted in SORT or HOLD SHALL abort the operation with no median emitted.
REQ-027 The full output SHALL be 1 once the fill counter equals WINDOW, and SHALL stay 1 until reset or clr.

Reset
REQ-028 HARD_RESET=1 SHALL immediately set FSM to IDLE, in_ready=1, out_valid=0, out_data=0, full=0, fill counter 0, write pointer 0, ring and sort array 0.
REQ-029 HARD_RESET asserted mid-SORT or mid-HOLD SHALL discard the operation; the first median after release SHALL require WINDOW new accepts.

Configuration
REQ-030 The block SHALL support exactly one compile-time macro, MEDIAN_SIGNED_EN, which selects the comparison mode.
REQ-031 With MEDIAN_SIGNED_EN defined, all comparisons SHALL treat samples as two's-complement signed.
REQ-032 Without MEDIAN_SIGNED_EN defined, all comparisons SHALL be unsigned, as in REQ-024; ports SHALL be identical in both builds.

Verification
REQ-033 Defaults: accept 5,1,9,3,7,2,8,6,4 back-to-back with out_ready=1 -> no out_valid before the 9th accept; out_data=5 exactly 10 edges after the 9th accept; full=1.
REQ-034 Sliding window: following REQ-033, accept 100 -> window {1,9,3,7,2,8,6,4,100} -> out_data=6; then accept 0 -> window {9,3,7,2,8,6,4,100,0} -> out_data=6.
REQ-035 Backpressure: hold out_ready=0 for 20 cycles while in HOLD with in_valid=1 -> out_data stable, in_ready=0, no sample accepted; out_ready=1 -> IDLE next edge.
REQ-036 Flush: assert clr during SORT -> out_valid stays 0, full=0; the next 8 accepts produce no output and the 9th does.
REQ-037 Async reset: pulse HARD_RESET between clk edges in HOLD -> out_valid=0, out_data=0 and in_ready=1 immediately, without waiting for a clk edge.
REQ-038 Signed mode: with MEDIAN_SIGNED_EN, WIDTH=16, accept 16'hFFFF (-1) x5 then 16'h0001 x4 -> out_data=16'hFFFF; the unsigned build with the same stimulus -> out_data=16'hFFFF, and with 16'h0001 x5 then 16'hFFFF x4 -> out_data=16'h0001 in both builds.
